// File: rtl/modexp_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | modexp_ctrl_if                                                              |
// | Command, multiplier-handshake and writeback-strobe bundle for modexp_ctrl.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
interface modexp_ctrl_if #(
  parameter int E_WIDTH = 1024
);
  logic               start;
  logic [E_WIDTH-1:0] exp_in;
  logic               busy;
  logic               done;
  logic               mul_start;
  logic [1:0]         mul_op;
  logic               mul_done;
  logic               acc_load;
  logic               wb_xt;
  logic               wb_acc;
  logic [15:0]        mul_count;
  logic [3:0]         state_dbg;

  modport master (
    input  start, exp_in, mul_done,
    output busy, done, mul_start, mul_op, acc_load, wb_xt, wb_acc, mul_count, state_dbg
  );

  modport slave (
    output start, exp_in, mul_done,
    input  busy, done, mul_start, mul_op, acc_load, wb_xt, wb_acc, mul_count, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/modexp_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | modexp_ctrl                                                                 |
// | Left-to-right square-and-multiply sequencer for a shared Montgomery         |
// | multiplier. MODEXP_CONST_TIME_EN selects the constant-time schedule.        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module modexp_ctrl #(
  parameter int E_WIDTH = 1024,
  parameter int IDX_W   = 10
) (
  input  logic          clk,
  input  logic          reset,
  modexp_ctrl_if.master bus
);

  localparam logic [1:0]       c_op_tox  = 2'd0;
  localparam logic [1:0]       c_op_sqr  = 2'd1;
  localparam logic [1:0]       c_op_mul  = 2'd2;
  localparam logic [1:0]       c_op_from = 2'd3;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(E_WIDTH - 1);

`ifdef MODEXP_CONST_TIME_EN
  localparam bit c_const_time = 1'b1;
`else
  localparam bit c_const_time = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INIT   = 4'd1,
    S_W_TOX  = 4'd2,
    S_SCAN   = 4'd3,
    S_SQR    = 4'd4,
    S_W_SQR  = 4'd5,
    S_MUL    = 4'd6,
    S_W_MUL  = 4'd7,
    S_NEXT   = 4'd8,
    S_FROM   = 4'd9,
    S_W_FROM = 4'd10,
    S_DONE   = 4'd11
  } state_t;

  state_t             r_state;
  logic [E_WIDTH-1:0] r_exp;
  logic [IDX_W-1:0]   r_idx;
  logic               w_bit;
  logic               w_op_done;

  assign w_bit         = r_exp[r_idx];
  // A completion coinciding with our own issue pulse belongs to no op of ours.
  assign w_op_done     = bus.mul_done & ~bus.mul_start;
  assign bus.state_dbg = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_exp         <= '0;
      r_idx         <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.mul_start <= 1'b0;
      bus.mul_op    <= c_op_tox;
      bus.acc_load  <= 1'b0;
      bus.wb_xt     <= 1'b0;
      bus.wb_acc    <= 1'b0;
      bus.mul_count <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.mul_start <= 1'b0;
      bus.acc_load  <= 1'b0;
      bus.wb_xt     <= 1'b0;
      bus.wb_acc    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_exp         <= bus.exp_in;
            r_idx         <= c_last_idx;
            bus.mul_count <= '0;
            bus.busy      <= 1'b1;
            bus.acc_load  <= 1'b1;
            r_state       <= S_INIT;
          end
        end
        S_INIT: begin
          bus.mul_start <= 1'b1;
          bus.mul_op    <= c_op_tox;
          bus.mul_count <= bus.mul_count + 16'd1;
          r_state       <= S_W_TOX;
        end
        S_W_TOX: begin
          if (w_op_done) begin
            bus.wb_xt <= 1'b1;
            r_state   <= c_const_time ? S_SQR : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_bit) begin
            r_state <= S_SQR;
          end else if (r_idx == '0) begin
            r_state <= S_FROM;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        S_SQR: begin
          bus.mul_start <= 1'b1;
          bus.mul_op    <= c_op_sqr;
          bus.mul_count <= bus.mul_count + 16'd1;
          r_state       <= S_W_SQR;
        end
        S_W_SQR: begin
          if (w_op_done) begin
            bus.wb_acc <= 1'b1;
            r_state    <= (w_bit || c_const_time) ? S_MUL : S_NEXT;
          end
        end
        S_MUL: begin
          bus.mul_start <= 1'b1;
          bus.mul_op    <= c_op_mul;
          bus.mul_count <= bus.mul_count + 16'd1;
          r_state       <= S_W_MUL;
        end
        S_W_MUL: begin
          if (w_op_done) begin
            // A multiply on a zero bit is a timing dummy; its result is dropped.
            bus.wb_acc <= w_bit;
            r_state    <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_idx == '0) begin
            r_state <= S_FROM;
          end else begin
            r_idx   <= r_idx - IDX_W'(1);
            r_state <= S_SQR;
          end
        end
        S_FROM: begin
          bus.mul_start <= 1'b1;
          bus.mul_op    <= c_op_from;
          bus.mul_count <= bus.mul_count + 16'd1;
          r_state       <= S_W_FROM;
        end
        S_W_FROM: begin
          if (w_op_done) begin
            bus.wb_acc <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_modexp_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_modexp_ctrl                                                              |
// | Mock 4/5-cycle multiplier, op-list reference model and per-cycle monitor.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_modexp_ctrl;
  localparam int EW = 8;
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_INIT  = 4'd1;
  localparam logic [3:0] ST_SCAN  = 4'd3;
  localparam logic [3:0] ST_SQR   = 4'd4;
  localparam logic [3:0] ST_W_MUL = 4'd7;
  localparam int OP_TOX = 0, OP_SQR = 1, OP_MUL = 2, OP_FROM = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  modexp_ctrl_if #(.E_WIDTH(EW)) bus ();
  modexp_ctrl #(.E_WIDTH(EW), .IDX_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass = 0;
  int n_total = 0;
  int model_ops[$];
  int model_wbacc;
  int model_lz;
  int rec_ops[$];
  int op_i, wbxt_n, wbacc_n, done_n, scan_zero, acc_cyc, ms_cyc, out_op;
  int cyc = 0;
  int pend = 0;
  bit outstanding = 1'b0;
  bit inj = 1'b0;
  logic [3:0] prev_state = 4'd0;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference: the op list square-and-multiply must produce for exponent e.
  function automatic void build_model(input logic [EW-1:0] e);
    model_ops.delete();
    model_ops.push_back(OP_TOX);
    model_wbacc = 1;
`ifdef MODEXP_CONST_TIME_EN
    model_lz = 0;
    for (int i = EW - 1; i >= 0; i--) begin
      model_ops.push_back(OP_SQR);
      model_ops.push_back(OP_MUL);
      model_wbacc += 1 + int'(e[i]);
    end
`else
    begin : g_lr
      int msb;
      msb = -1;
      for (int i = EW - 1; i >= 0; i--) if (e[i] && msb < 0) msb = i;
      model_lz = (msb < 0) ? EW : EW - 1 - msb;
      for (int i = msb; i >= 0; i--) begin
        model_ops.push_back(OP_SQR);
        model_wbacc++;
        if (e[i]) begin
          model_ops.push_back(OP_MUL);
          model_wbacc++;
        end
      end
    end
`endif
    model_ops.push_back(OP_FROM);
  endfunction

  function automatic int trace_diff_0b();
    int lit[9] = '{0, 1, 2, 1, 1, 2, 1, 2, 3};
    int d;
    d = (rec_ops.size() != 9) ? 1 : 0;
    for (int i = 0; i < 9 && i < rec_ops.size(); i++) if (rec_ops[i] != lit[i]) d++;
    return d;
  endfunction

  // Mock multiplier: completes each op a fixed number of cycles after issue.
  always begin
    bit fire;
    @(negedge clk);
    fire = 1'b0;
    if (reset) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) fire = 1'b1;
      end
      if (bus.mul_start) pend = 4;
    end
    bus.mul_done = fire | (inj & ~reset & ((bus.state_dbg == ST_SQR) | bus.mul_start));
  end

  // Per-cycle compare process.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mul_start) begin
      if (op_i < model_ops.size()) chk("op_seq", int'(bus.mul_op), model_ops[op_i]);
      else chk("op_extra", op_i, model_ops.size());
      chk("mul_count_run", int'(bus.mul_count), op_i + 1);
      rec_ops.push_back(int'(bus.mul_op));
      if (op_i == 0) ms_cyc = cyc;
      op_i++;
      outstanding = 1'b1;
      out_op = int'(bus.mul_op);
    end else if (outstanding && bus.mul_done) begin
      chk("op_held", int'(bus.mul_op), out_op);
      outstanding = 1'b0;
    end
    if (bus.acc_load && acc_cyc < 0) acc_cyc = cyc;
    if (bus.wb_xt) wbxt_n++;
    if (bus.wb_acc) wbacc_n++;
    if (bus.done) begin
      done_n++;
      chk("busy_at_done", int'(bus.busy), 0);
    end
    if (prev_state == ST_SCAN && bus.state_dbg != ST_SQR) scan_zero++;
    prev_state = bus.state_dbg;
  end

  task automatic start_exp(input logic [EW-1:0] e);
    build_model(e);
    rec_ops.delete();
    op_i = 0; wbxt_n = 0; wbacc_n = 0; done_n = 0; scan_zero = 0;
    acc_cyc = -1; ms_cyc = -1; outstanding = 1'b0;
    @(negedge clk);
    bus.exp_in = e;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", int'(bus.busy), 1);
    chk("init_state", int'(bus.state_dbg), int'(ST_INIT));
  endtask

  task automatic finish_exp(input logic [EW-1:0] e, input bit spur, output int cycles);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 1000) begin
      @(negedge clk);
      n++;
      if (spur && n == 20) begin
        bus.exp_in = ~e;
        bus.start  = 1'b1;
      end else bus.start = 1'b0;
      if (done_n > 0) got = 1'b1;
    end
    cycles = n;
    if (!got) chk("done_timeout", 0, 1);
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    chk("ops_issued", op_i, model_ops.size());
    chk("mul_count", int'(bus.mul_count), model_ops.size());
    chk("wb_xt_n", wbxt_n, 1);
    chk("wb_acc_n", wbacc_n, model_wbacc);
    chk("done_n", done_n, 1);
    chk("acc_before_mul", int'(acc_cyc >= 0 && acc_cyc < ms_cyc), 1);
    chk("scan_zero", scan_zero, model_lz);
    chk("idle_after", int'(bus.state_dbg), int'(ST_IDLE));
    chk("busy_after", int'(bus.busy), 0);
  endtask

  initial begin
    int c_b, c_x, n;
    logic [EW-1:0] e;
    bus.start  = 1'b0;
    bus.exp_in = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_mul_start", int'(bus.mul_start), 0);
    chk("rst_mul_op", int'(bus.mul_op), 0);
    chk("rst_acc_load", int'(bus.acc_load), 0);
    chk("rst_wb_xt", int'(bus.wb_xt), 0);
    chk("rst_wb_acc", int'(bus.wb_acc), 0);
    chk("rst_mul_count", int'(bus.mul_count), 0);
    chk("rst_state", int'(bus.state_dbg), int'(ST_IDLE));
    reset = 1'b0;

    start_exp(8'h0B);
    finish_exp(8'h0B, 1'b0, c_b);
`ifdef MODEXP_CONST_TIME_EN
    chk("ct_count_0b", int'(bus.mul_count), 18);
    chk("ct_wbacc_0b", wbacc_n, 12);
    start_exp(8'hFF);
    finish_exp(8'hFF, 1'b0, c_x);
    chk("ct_cycles_0b_vs_ff", c_x, c_b);
    chk("ct_count_ff", int'(bus.mul_count), 18);
`else
    chk("trace_0b", trace_diff_0b(), 0);
    chk("count_0b", int'(bus.mul_count), 9);
    chk("wbacc_0b", wbacc_n, 8);
    chk("scan_0b", scan_zero, 4);

    start_exp(8'h00);
    finish_exp(8'h00, 1'b0, c_x);
    chk("trace_00", int'(rec_ops.size() == 2 && rec_ops[0] == 0 && rec_ops[1] == 3), 1);
    chk("scan_00", scan_zero, 8);

    start_exp(8'h80);
    finish_exp(8'h80, 1'b0, c_x);
    chk("count_80", int'(bus.mul_count), 11);
`endif

    inj = 1'b1;
    start_exp(8'h0B);
    finish_exp(8'h0B, 1'b1, c_x);
    inj = 1'b0;
`ifdef MODEXP_CONST_TIME_EN
    chk("spur_count_0b", int'(bus.mul_count), 18);
`else
    chk("spur_trace_0b", trace_diff_0b(), 0);
    chk("spur_count_0b", int'(bus.mul_count), 9);
`endif

    start_exp(8'h0B);
    n = 0;
    while (bus.state_dbg != ST_W_MUL && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_w_mul", int'(bus.state_dbg == ST_W_MUL), 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_mul_start", int'(bus.mul_start), 0);
    chk("midrst_state", int'(bus.state_dbg), int'(ST_IDLE));
    chk("midrst_count", int'(bus.mul_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_exp(8'h0B);
    finish_exp(8'h0B, 1'b0, c_x);
`ifndef MODEXP_CONST_TIME_EN
    chk("post_rst_trace_0b", trace_diff_0b(), 0);
`endif

    for (int k = 0; k < 12; k++) begin
      e = EW'($urandom_range(0, 255));
      start_exp(e);
      finish_exp(e, 1'b0, c_x);
    end
    start_exp(8'h01);
    finish_exp(8'h01, 1'b0, c_x);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
